// File: rtl/ufm_read_arbiter.sv
// ufm_read_arbiter: shares the single UFM Avalon-MM read port
// between the boot shadow-copy engine (port 0) and the host (port 1).
module ufm_read_arbiter #(
  parameter int ADDR_W         = 9,
  parameter int BURST_W        = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               boot_done_i,
  input  logic               m0_read_i,
  input  logic [ADDR_W-1:0]  m0_addr_i,
  input  logic [BURST_W-1:0] m0_burst_count_i,
  output logic               m0_wait_req_o,
  output logic               m0_valid_o,
  output logic [DATA_W-1:0]  m0_data_o,
  input  logic               m1_read_i,
  input  logic [ADDR_W-1:0]  m1_addr_i,
  input  logic [BURST_W-1:0] m1_burst_count_i,
  output logic               m1_wait_req_o,
  output logic               m1_valid_o,
  output logic [DATA_W-1:0]  m1_data_o,
  output logic               ufm_read_o,
  output logic [ADDR_W-1:0]  ufm_addr_o,
  output logic [BURST_W-1:0] ufm_burst_count_o,
  input  logic               ufm_wait_req_i,
  input  logic               ufm_valid_i,
  input  logic [DATA_W-1:0]  ufm_data_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DATA
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_owner;
  logic               r_last_grant;
  logic               r_read;
  logic               r_err;
  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_beat_cnt;
  logic [TW-1:0]      r_timer;

  logic               w_e0;
  logic               w_e1;
  logic               w_gnt;
  logic               w_gnt_id;
  logic               w_accept;
  logic               w_last_beat;
  logic               w_timeout;
  logic               w_spur;
  logic [ADDR_W-1:0]  w_addr;
  logic [BURST_W-1:0] w_burst_raw;
  logic [BURST_W-1:0] w_burst;

  // Port 1 is only eligible once boot is done; ties go away from last_grant
  assign w_e0        = m0_read_i;
  assign w_e1        = m1_read_i & boot_done_i;
  assign w_gnt       = (r_state == S_IDLE) & (w_e0 | w_e1);
  assign w_gnt_id    = w_e1 & (~w_e0 | ~r_last_grant);
  assign w_addr      = w_gnt_id ? m1_addr_i : m0_addr_i;
  assign w_burst_raw = w_gnt_id ? m1_burst_count_i : m0_burst_count_i;
  assign w_burst     = (w_burst_raw == '0) ? BURST_W'(1) : w_burst_raw;

  assign w_accept    = (r_state == S_ISSUE) & ~ufm_wait_req_i;
  assign w_last_beat = (r_state == S_DATA) & ufm_valid_i &
                       ((r_beat_cnt + BURST_W'(1)) == r_burst);
  assign w_timeout   = TO_EN & (r_state == S_DATA) & ~ufm_valid_i &
                       ((r_timer + TW'(1)) == TO_LIM);
  assign w_spur      = ufm_valid_i & (r_state != S_DATA);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_accept) w_state_nxt = S_DATA;
      S_DATA:  if (w_last_beat | w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, beat/idle counters and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_read       <= 1'b0;
      r_addr       <= '0;
      r_burst      <= '0;
      r_beat_cnt   <= '0;
      r_timer      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_owner <= w_gnt_id;
        r_addr  <= w_addr;
        r_burst <= w_burst;
        r_read  <= 1'b1;
      end
      if (w_accept) begin
        r_read       <= 1'b0;
        r_last_grant <= r_owner;
      end
      if (r_state != S_DATA || w_last_beat || w_timeout)
        r_beat_cnt <= '0;
      else if (ufm_valid_i)
        r_beat_cnt <= r_beat_cnt + BURST_W'(1);
      if (r_state == S_DATA && !ufm_valid_i && !w_timeout)
        r_timer <= r_timer + TW'(1);
      else
        r_timer <= '0;
      if (w_spur || w_timeout)
        r_err <= 1'b1;
    end
  end

  // Requester handshakes and data routing
  always_comb begin
    busy_o        = (r_state != S_IDLE);
    m0_wait_req_o = 1'b1;
    m1_wait_req_o = 1'b1;
    if (r_state == S_ISSUE) begin
      if (r_owner) m1_wait_req_o = ufm_wait_req_i;
      else         m0_wait_req_o = ufm_wait_req_i;
    end
    m0_valid_o = ufm_valid_i & ~r_owner & (r_state == S_DATA);
    m1_valid_o = ufm_valid_i &  r_owner & (r_state == S_DATA);
  end

  assign m0_data_o         = ufm_data_i;
  assign m1_data_o         = ufm_data_i;
  assign ufm_read_o        = r_read;
  assign ufm_addr_o        = r_addr;
  assign ufm_burst_count_o = r_burst;
  assign err_o             = r_err;

endmodule

// File: tb/tb_ufm_read_arbiter.sv
// tb_ufm_read_arbiter: directed bench for ufm_read_arbiter
// with a short idle timeout of 8 cycles.
module tb_ufm_read_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        boot_done_i;
  logic        m0_read_i;
  logic [8:0]  m0_addr_i;
  logic [1:0]  m0_burst_count_i;
  logic        m0_wait_req_o;
  logic        m0_valid_o;
  logic [31:0] m0_data_o;
  logic        m1_read_i;
  logic [8:0]  m1_addr_i;
  logic [1:0]  m1_burst_count_i;
  logic        m1_wait_req_o;
  logic        m1_valid_o;
  logic [31:0] m1_data_o;
  logic        ufm_read_o;
  logic [8:0]  ufm_addr_o;
  logic [1:0]  ufm_burst_count_o;
  logic        ufm_wait_req_i;
  logic        ufm_valid_i;
  logic [31:0] ufm_data_i;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  ufm_read_arbiter #(
    .ADDR_W(9), .BURST_W(2), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .boot_done_i(boot_done_i),
    .m0_read_i(m0_read_i), .m0_addr_i(m0_addr_i),
    .m0_burst_count_i(m0_burst_count_i),
    .m0_wait_req_o(m0_wait_req_o), .m0_valid_o(m0_valid_o),
    .m0_data_o(m0_data_o),
    .m1_read_i(m1_read_i), .m1_addr_i(m1_addr_i),
    .m1_burst_count_i(m1_burst_count_i),
    .m1_wait_req_o(m1_wait_req_o), .m1_valid_o(m1_valid_o),
    .m1_data_o(m1_data_o),
    .ufm_read_o(ufm_read_o), .ufm_addr_o(ufm_addr_o),
    .ufm_burst_count_o(ufm_burst_count_o),
    .ufm_wait_req_i(ufm_wait_req_i), .ufm_valid_i(ufm_valid_i),
    .ufm_data_i(ufm_data_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; boot_done_i = 1'b0;
    m0_read_i = 1'b0; m0_addr_i = '0; m0_burst_count_i = '0;
    m1_read_i = 1'b0; m1_addr_i = '0; m1_burst_count_i = '0;
    ufm_wait_req_i = 1'b1; ufm_valid_i = 1'b1; ufm_data_i = '0;
    #23;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
    total++; if (ufm_read_o !== 1'b0) begin bad++; $display("FAIL rst_read got=%b exp=0", ufm_read_o); end
    total++; if (ufm_addr_o !== 9'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", ufm_addr_o); end
    total++; if (ufm_burst_count_o !== 2'd0) begin bad++; $display("FAIL rst_burst got=%0d exp=0", ufm_burst_count_o); end
    total++; if (m0_wait_req_o !== 1'b1 || m1_wait_req_o !== 1'b1) begin bad++; $display("FAIL rst_wait got=%b%b exp=11", m0_wait_req_o, m1_wait_req_o); end
    total++; if (m0_valid_o !== 1'b0 || m1_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b%b exp=00", m0_valid_o, m1_valid_o); end
    ufm_valid_i = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_round_robin();
    logic g;
    boot_done_i = 1'b1;
    m0_read_i = 1'b1; m0_addr_i = 9'h0A5; m0_burst_count_i = 2'd1;
    m1_read_i = 1'b1; m1_addr_i = 9'h15A; m1_burst_count_i = 2'd1;
    ufm_wait_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      g = i[0];
      cyc();
      #1;
      total++; if (ufm_addr_o !== (g ? 9'h15A : 9'h0A5)) begin bad++; $display("FAIL rr_addr%0d got=%h exp=%h", i, ufm_addr_o, g ? 9'h15A : 9'h0A5); end
      total++; if (m0_wait_req_o !== g || m1_wait_req_o !== ~g) begin bad++; $display("FAIL rr_wait%0d got=%b%b exp=%b%b", i, m0_wait_req_o, m1_wait_req_o, g, ~g); end
      cyc();
      ufm_valid_i = 1'b1; ufm_data_i = 32'h1000 + i;
      #1;
      total++; if (m0_valid_o !== ~g || m1_valid_o !== g) begin bad++; $display("FAIL rr_valid%0d got=%b%b exp=%b%b", i, m0_valid_o, m1_valid_o, ~g, g); end
      total++; if (m1_data_o !== 32'h1000 + i) begin bad++; $display("FAIL rr_data%0d got=%h exp=%h", i, m1_data_o, 32'h1000 + i); end
      cyc();
      ufm_valid_i = 1'b0;
    end
    m0_read_i = 1'b0; m1_read_i = 1'b0;
    cyc();
  endtask

  task automatic test_port0();
    ufm_wait_req_i = 1'b1;
    m0_read_i = 1'b1; m0_addr_i = 9'h010; m0_burst_count_i = 2'd2;
    cyc();
    total++; if (ufm_read_o !== 1'b1 || ufm_addr_o !== 9'h010 || ufm_burst_count_o !== 2'd2) begin bad++; $display("FAIL p0_cmd got=%b/%h/%0d exp=1/010/2", ufm_read_o, ufm_addr_o, ufm_burst_count_o); end
    for (int i = 0; i < 3; i++) begin
      total++; if (m0_wait_req_o !== 1'b1 || ufm_read_o !== 1'b1) begin bad++; $display("FAIL p0_hold%0d got=%b/%b exp=1/1", i, m0_wait_req_o, ufm_read_o); end
      cyc();
    end
    ufm_wait_req_i = 1'b0;
    #1;
    total++; if (m0_wait_req_o !== 1'b0 || m1_wait_req_o !== 1'b1) begin bad++; $display("FAIL p0_accept got=%b%b exp=01", m0_wait_req_o, m1_wait_req_o); end
    cyc();
    m0_read_i = 1'b0; ufm_wait_req_i = 1'b1;
    total++; if (ufm_read_o !== 1'b0 || busy_o !== 1'b1 || m0_wait_req_o !== 1'b1) begin bad++; $display("FAIL p0_data got=%b/%b/%b exp=0/1/1", ufm_read_o, busy_o, m0_wait_req_o); end
    for (int i = 0; i < 4; i++) begin
      total++; if (m0_valid_o !== 1'b0) begin bad++; $display("FAIL p0_gap%0d got=%b exp=0", i, m0_valid_o); end
      cyc();
    end
    ufm_valid_i = 1'b1; ufm_data_i = 32'h55555555;
    #1;
    total++; if (m0_valid_o !== 1'b1 || m0_data_o !== 32'h55555555 || m1_valid_o !== 1'b0) begin bad++; $display("FAIL p0_beat0 got=%b/%h/%b exp=1/55555555/0", m0_valid_o, m0_data_o, m1_valid_o); end
    cyc();
    ufm_data_i = 32'hAAAAAAAA;
    #1;
    total++; if (m0_valid_o !== 1'b1 || m0_data_o !== 32'hAAAAAAAA || m1_valid_o !== 1'b0) begin bad++; $display("FAIL p0_beat1 got=%b/%h/%b exp=1/aaaaaaaa/0", m0_valid_o, m0_data_o, m1_valid_o); end
    cyc();
    ufm_valid_i = 1'b0;
    total++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL p0_done got=%b/%b exp=0/0", busy_o, err_o); end
  endtask

  task automatic test_boot_lock();
    boot_done_i = 1'b0; ufm_wait_req_i = 1'b0;
    m0_read_i = 1'b1; m0_addr_i = 9'h033; m0_burst_count_i = 2'd1;
    m1_read_i = 1'b1; m1_addr_i = 9'h1CC; m1_burst_count_i = 2'd1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      total++; if (ufm_addr_o !== 9'h033 || m0_wait_req_o !== 1'b0 || m1_wait_req_o !== 1'b1) begin bad++; $display("FAIL boot_issue%0d got=%h/%b%b exp=033/01", i, ufm_addr_o, m0_wait_req_o, m1_wait_req_o); end
      cyc();
      ufm_valid_i = 1'b1;
      #1;
      total++; if (m0_valid_o !== 1'b1 || m1_valid_o !== 1'b0 || m1_wait_req_o !== 1'b1) begin bad++; $display("FAIL boot_data%0d got=%b%b/%b exp=10/1", i, m0_valid_o, m1_valid_o, m1_wait_req_o); end
      cyc();
      ufm_valid_i = 1'b0;
    end
    m0_read_i = 1'b0; m1_read_i = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    boot_done_i = 1'b1; ufm_wait_req_i = 1'b0;
    m1_read_i = 1'b1; m1_addr_i = 9'h123; m1_burst_count_i = 2'd3;
    cyc();
    total++; if (ufm_addr_o !== 9'h123 || ufm_burst_count_o !== 2'd3) begin bad++; $display("FAIL b2b_p1cmd got=%h/%0d exp=123/3", ufm_addr_o, ufm_burst_count_o); end
    cyc();
    m1_read_i = 1'b0;
    m0_read_i = 1'b1; m0_addr_i = 9'h1F0; m0_burst_count_i = 2'd0;
    for (int i = 0; i < 3; i++) begin
      ufm_valid_i = 1'b1;
      #1;
      total++; if (m0_wait_req_o !== 1'b1 || m1_valid_o !== 1'b1 || m0_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_beat%0d got=%b/%b%b exp=1/10", i, m0_wait_req_o, m1_valid_o, m0_valid_o); end
      cyc();
    end
    ufm_valid_i = 1'b0;
    total++; if (busy_o !== 1'b0 || m0_wait_req_o !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=0/1", busy_o, m0_wait_req_o); end
    cyc();
    total++; if (ufm_read_o !== 1'b1 || ufm_addr_o !== 9'h1F0 || m0_wait_req_o !== 1'b0) begin bad++; $display("FAIL b2b_p0cmd got=%b/%h/%b exp=1/1f0/0", ufm_read_o, ufm_addr_o, m0_wait_req_o); end
    total++; if (ufm_burst_count_o !== 2'd1) begin bad++; $display("FAIL b2b_burst0 got=%0d exp=1", ufm_burst_count_o); end
    cyc();
    m0_read_i = 1'b0;
    ufm_valid_i = 1'b1;
    cyc();
    ufm_valid_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", busy_o); end
  endtask

  task automatic test_timeout();
    ufm_wait_req_i = 1'b0;
    m0_read_i = 1'b1; m0_addr_i = 9'h077; m0_burst_count_i = 2'd2;
    cyc();
    cyc();
    m0_read_i = 1'b0;
    ufm_valid_i = 1'b1;
    cyc();
    ufm_valid_i = 1'b0;
    for (int i = 1; i < 8; i++) begin
      cyc();
      total++; if (busy_o !== 1'b1 || err_o !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%b/%b exp=1/0", i, busy_o, err_o); end
    end
    cyc();
    total++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL to_abort got=%b/%b exp=1/0", err_o, busy_o); end
    ufm_valid_i = 1'b1;
    #1;
    total++; if (m0_valid_o !== 1'b0 || m1_valid_o !== 1'b0) begin bad++; $display("FAIL to_spur got=%b%b exp=00", m0_valid_o, m1_valid_o); end
    cyc();
    ufm_valid_i = 1'b0;
    total++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL to_sticky got=%b/%b exp=1/0", err_o, busy_o); end
    m0_read_i = 1'b1; m0_burst_count_i = 2'd1;
    cyc();
    total++; if (busy_o !== 1'b1 || ufm_read_o !== 1'b1) begin bad++; $display("FAIL to_regrant got=%b/%b exp=1/1", busy_o, ufm_read_o); end
    cyc();
    m0_read_i = 1'b0;
    ufm_valid_i = 1'b1;
    cyc();
    ufm_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    ufm_wait_req_i = 1'b0;
    m0_read_i = 1'b1; m0_addr_i = 9'h0F0; m0_burst_count_i = 2'd2;
    cyc();
    cyc();
    m0_read_i = 1'b0;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy_o); end
    reset_n = 1'b0;
    ufm_valid_i = 1'b1;
    #1;
    total++; if (busy_o !== 1'b0 || err_o !== 1'b0 || ufm_read_o !== 1'b0) begin bad++; $display("FAIL mid_rst got=%b/%b/%b exp=0/0/0", busy_o, err_o, ufm_read_o); end
    total++; if (ufm_addr_o !== 9'h0 || ufm_burst_count_o !== 2'd0) begin bad++; $display("FAIL mid_cmd got=%h/%0d exp=0/0", ufm_addr_o, ufm_burst_count_o); end
    total++; if (m0_wait_req_o !== 1'b1 || m1_wait_req_o !== 1'b1 || m0_valid_o !== 1'b0 || m1_valid_o !== 1'b0) begin bad++; $display("FAIL mid_port got=%b%b/%b%b exp=11/00", m0_wait_req_o, m1_wait_req_o, m0_valid_o, m1_valid_o); end
    #2;
    ufm_valid_i = 1'b0;
    reset_n = 1'b1;
    boot_done_i = 1'b1;
    m0_read_i = 1'b1; m0_addr_i = 9'h0AB; m0_burst_count_i = 2'd1;
    m1_read_i = 1'b1; m1_addr_i = 9'h1BA; m1_burst_count_i = 2'd1;
    cyc();
    #1;
    total++; if (ufm_addr_o !== 9'h0AB || m0_wait_req_o !== 1'b0 || m1_wait_req_o !== 1'b1) begin bad++; $display("FAIL mid_first got=%h/%b%b exp=0ab/01", ufm_addr_o, m0_wait_req_o, m1_wait_req_o); end
    m0_read_i = 1'b0; m1_read_i = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_port0();
    test_boot_lock();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ufm_read_arbiter.md
Name: ufm_read_arbiter

Overview:
- Shares the single UFM Avalon-MM read port between two requesters. Port 0 is the boot shadow-copy engine. Port 1 is the runtime host/CPU read path.
- Allows one outstanding burst at a time. Grant is held until every beat of that burst has returned.
- While boot_done_i is low, only port 0 may be granted. After boot, grant alternates round-robin between the ports.
- Sits between the requesters and the UFM IP, so the shadow copy and host reads cannot collide on the flash.

Parameters:
- ADDR_W, 9, UFM word address width.
- BURST_W, 2, burst count width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 1024, maximum idle cycles between beats before a burst is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous assert, active-low
- boot_done_i  in  1  high = port 1 may be granted
- m0_read_i  in  1  port 0 read request
- m0_addr_i  in  ADDR_W  port 0 address
- m0_burst_count_i  in  BURST_W  port 0 beats
- m0_wait_req_o  out  1  port 0 waitrequest
- m0_valid_o  out  1  port 0 readdatavalid
- m0_data_o  out  DATA_W  port 0 read data
- m1_read_i, m1_addr_i, m1_burst_count_i, m1_wait_req_o, m1_valid_o, m1_data_o: same as port 0, for port 1
- ufm_read_o  out  1  UFM read
- ufm_addr_o  out  ADDR_W  UFM address
- ufm_burst_count_o  out  BURST_W  UFM burst count
- ufm_wait_req_i  in  1  UFM waitrequest
- ufm_valid_i  in  1  UFM readdatavalid
- ufm_data_i  in  DATA_W  UFM read data
- busy_o  out  1  high when state is not IDLE
- err_o  out  1  sticky error flag, cleared only by reset

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, owner=0, last_grant=1, beat_cnt=0, timer=0, ufm_read_o=0, ufm_addr_o=0, ufm_burst_count_o=0, err_o=0, busy_o=0. m0_wait_req_o=m1_wait_req_o=1 and m0_valid_o=m1_valid_o=0 while in reset.
- State machine, IDLE:
  - Eligible ports: port 0 if m0_read_i. Port 1 if m1_read_i and boot_done_i.
  - One eligible port: grant it.
  - Both eligible: grant the port that is not last_grant.
  - On grant, at the next edge: latch owner, address and burst into ufm_addr_o and ufm_burst_count_o; set ufm_read_o=1; go to ISSUE.
  - A burst count of 0 is latched as 1.
- State machine, ISSUE:
  - ufm_read_o is held at 1 with stable address and burst.
  - Owner waitrequest equals ufm_wait_req_i (combinational). The other port's waitrequest is 1.
  - When ufm_wait_req_i=0, the command is accepted: at that edge ufm_read_o goes to 0, last_grant becomes owner, and the state goes to DATA.
- State machine, DATA:
  - Each ufm_valid_i increments beat_cnt.
  - When beat_cnt+1 equals the burst on a valid beat, go to IDLE at that edge and clear beat_cnt.
  - A new grant can be issued no earlier than the cycle after the last beat.
- Requester waitrequest: outside ISSUE, both wait_req_o are 1. The requester must hold read until its waitrequest samples 0 (Avalon rule).
- Data routing:
  - mN_data_o = ufm_data_i, combinational, at both ports at all times.
  - mN_valid_o = ufm_valid_i & (owner==N) & (state==DATA), combinational, zero-cycle latency.
- Spurious data: ufm_valid_i in IDLE or ISSUE is dropped and sets err_o.
- Timeout:
  - In DATA, the timer counts cycles without ufm_valid_i and resets on each beat.
  - When the timer reaches TIMEOUT_CYCLES (nonzero), set err_o, go to IDLE and clear beat_cnt.
  - Late beats after the abort are then spurious.
- Priority: boot_done_i falling after boot has no effect on a burst in flight. It only restricts new grants.
- Simultaneous events: a request that arrives in the same cycle as the final beat is granted from IDLE on the following cycle.

Test Plan:
- Port 0 only, addr=0x010, burst=2, UFM waitrequest high 3 cycles, beats 5 cycles after accept with data 0x55555555 then 0xAAAAAAAA:
  - m0_wait_req_o goes low exactly on the accept cycle.
  - m0_valid_o is asserted twice with those data values.
  - m1_valid_o stays 0; state returns to IDLE; err_o=0.
- boot_done_i=0, both ports request continuously:
  - Only port 0 is granted; m1_wait_req_o stays 1 throughout.
- boot_done_i=1, both ports request back-to-back, burst=1 each:
  - Grants alternate 0,1,0,1.
  - ufm_addr_o alternates between m0_addr_i and m1_addr_i.
- Port 1 burst=3 in flight, port 0 requests during DATA:
  - Port 0 waitrequest stays 1 until the third beat.
  - Port 0 is issued on the next cycle with its own address.
- TIMEOUT_CYCLES=8, burst=2, only one beat returned:
  - 8 cycles after that beat, err_o=1, busy_o=0, and a new grant is possible.
  - Then ufm_valid_i pulsed in IDLE leaves err_o=1 and both valid outputs at 0.
- reset_n pulsed low mid-DATA:
  - All outputs return immediately to their reset values, without waiting for a clock edge.
  - After release, the next port 0 request is granted first.
